// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between packet sources, the arbiter and the uart transmitter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arb_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_DATA = 8
);
    logic [N_REQ*N_DATA-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_DATA-1:0]       tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output req_data, req_last, req_valid, tx_ready,
        input  req_ready, tx_data, tx_valid
    );

    modport slave (
        input  req_data, req_last, req_valid, tx_ready,
        output req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one uart transmitter, with optional source-ID
// header byte and a stall timeout that abandons a packet whose source goes quiet.
module uart_tx_arb #(
    parameter int unsigned       N_REQ   = 4,
    parameter int unsigned       N_DATA  = 8,
    parameter bit                HAS_HDR = 1'b1,
    parameter logic [N_DATA-1:0] HDR_TAG = 8'hA0,
    parameter int unsigned       TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arb_if.slave     bus,
    output logic [N_REQ-1:0] grant,
    output logic             abort
);
    localparam int unsigned SelW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [N_DATA-1:0] SelMask = N_DATA'((1 << SelW) - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [SelW-1:0]   last_sel_q, last_sel_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]  req_ready;
    logic [N_DATA-1:0] tx_data;
    logic              tx_valid;
    logic              cur_valid;
    logic              cur_last;
    logic [N_DATA-1:0] cur_data;
    logic              found;
    int unsigned       idx;

    assign cur_valid     = bus.req_valid[sel_q];
    assign cur_last      = bus.req_last[sel_q];
    assign cur_data      = bus.req_data[sel_q*N_DATA +: N_DATA];
    assign bus.req_ready = req_ready;
    assign bus.tx_data   = tx_data;
    assign bus.tx_valid  = tx_valid;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        cnt_d      = '0;
        abort      = 1'b0;
        grant      = '0;
        req_ready  = '0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        found      = 1'b0;
        idx        = 0;
        unique case (state_q)
            StIdle: begin
                // Search starts just after the previous owner so it is considered last.
                for (int unsigned i = 1; i <= N_REQ; i++) begin
                    idx = (32'(last_sel_q) + i) % N_REQ;
                    if (!found && bus.req_valid[idx]) begin
                        found = 1'b1;
                        sel_d = SelW'(idx);
                    end
                end
                if (found) begin
                    state_d = HAS_HDR ? StHdr : StData;
                end
            end
            StHdr: begin
                grant[sel_q] = 1'b1;
                tx_valid     = 1'b1;
                tx_data      = (HDR_TAG & ~SelMask) | N_DATA'(sel_q);
                if (bus.tx_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                grant[sel_q]     = 1'b1;
                tx_data          = cur_data;
                tx_valid         = cur_valid;
                req_ready[sel_q] = bus.tx_ready;
                if (cur_valid) begin
                    if (bus.tx_ready && cur_last) begin
                        state_d    = StIdle;
                        last_sel_d = sel_q;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    state_d    = StIdle;
                    last_sel_d = sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            last_sel_q <= SelW'(N_REQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (N_REQ=4, header on, TIMEOUT=16); the bench plays
// both the packet sources and the uart, with hand-computed expectations.
module tb_uart_tx_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] grant;
    logic       abort;
    int         n_chk  = 0;
    int         n_fail = 0;

    uart_tx_arb_if #(.N_REQ(4), .N_DATA(8)) bus ();

    uart_tx_arb #(
        .N_REQ  (4),
        .N_DATA (8),
        .HAS_HDR(1'b1),
        .HDR_TAG(8'hA0),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .grant(grant),
        .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [7:0] d, input logic v, input logic l);
        bus.req_data[i*8 +: 8] = d;
        bus.req_valid[i]       = v;
        bus.req_last[i]        = l;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] got_b[10];
        logic [3:0] got_g[10];
        int         nf;
        logic [7:0] exp_b;

        // Reset state, with sources already requesting
        do_reset();
        rst           = 1'b0;
        bus.req_valid = 4'hF;
        bus.tx_ready  = 1'b1;
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_abort", 32'(abort), 32'h0);

        // Single source 2: A2,11,22,33
        do_reset();
        set_src(2, 8'h11, 1'b1, 1'b0);
        bus.tx_ready = 1'b1;
        tick();
        chk("s2_hdr", 32'(bus.tx_data), 32'hA2);
        chk("s2_hdr_grant", 32'(grant), 32'h4);
        chk("s2_hdr_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("s2_b0", 32'(bus.tx_data), 32'h11);
        chk("s2_b0_ready", 32'(bus.req_ready), 32'h4);
        tick();
        set_src(2, 8'h22, 1'b1, 1'b0);
        #1;
        chk("s2_b1", 32'(bus.tx_data), 32'h22);
        chk("s2_b1_grant", 32'(grant), 32'h4);
        tick();
        set_src(2, 8'h33, 1'b1, 1'b1);
        #1;
        chk("s2_b2", 32'(bus.tx_data), 32'h33);
        tick();
        set_src(2, 8'h00, 1'b0, 1'b0);
        #1;
        chk("s2_idle_grant", 32'(grant), 32'h0);
        chk("s2_idle_valid", 32'(bus.tx_valid), 32'h0);
        chk("s2_idle_data", 32'(bus.tx_data), 32'h0);

        // All four sources, one-byte packets, continuously requesting
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 8'(8'h10 + i), 1'b1, 1'b1);
        bus.tx_ready = 1'b1;
        nf = 0;
        for (int c = 0; c < 60 && nf < 10; c++) begin
            tick();
            if (bus.tx_valid && bus.tx_ready) begin
                got_b[nf] = bus.tx_data;
                got_g[nf] = grant;
                nf++;
            end
        end
        chk("rr_fire_count", 32'(nf), 32'd10);
        for (int k = 0; k < 10; k++) begin
            exp_b = (k % 2 == 0) ? 8'(8'hA0 + (k / 2) % 4) : 8'(8'h10 + (k / 2) % 4);
            chk($sformatf("rr_byte%0d", k), 32'(got_b[k]), 32'(exp_b));
            chk($sformatf("rr_grant%0d", k), 32'(got_g[k]), 32'(1 << ((k / 2) % 4)));
        end

        // Source 3 arrives while source 1 is mid-packet
        do_reset();
        set_src(1, 8'h55, 1'b1, 1'b0);
        bus.tx_ready = 1'b1;
        tick();
        chk("mid_hdr1", 32'(bus.tx_data), 32'hA1);
        tick();
        chk("mid_b0", 32'(bus.tx_data), 32'h55);
        set_src(3, 8'h77, 1'b1, 1'b1);
        #1;
        chk("mid_ready_b0", 32'(bus.req_ready), 32'h2);
        chk("mid_grant_b0", 32'(grant), 32'h2);
        tick();
        set_src(1, 8'h56, 1'b1, 1'b1);
        #1;
        chk("mid_b1", 32'(bus.tx_data), 32'h56);
        chk("mid_ready_b1", 32'(bus.req_ready), 32'h2);
        tick();
        set_src(1, 8'h00, 1'b0, 1'b0);
        #1;
        chk("mid_idle_grant", 32'(grant), 32'h0);
        chk("mid_idle_valid", 32'(bus.tx_valid), 32'h0);
        tick();
        chk("mid_hdr3", 32'(bus.tx_data), 32'hA3);
        chk("mid_hdr3_grant", 32'(grant), 32'h8);
        chk("mid_hdr3_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mid_b3", 32'(bus.tx_data), 32'h77);
        chk("mid_b3_ready", 32'(bus.req_ready), 32'h8);

        // Stall timeout on source 0 while source 1 waits
        do_reset();
        set_src(0, 8'h99, 1'b1, 1'b0);
        bus.tx_ready = 1'b1;
        tick();
        chk("to_hdr0", 32'(bus.tx_data), 32'hA0);
        tick();
        chk("to_b0", 32'(bus.tx_data), 32'h99);
        tick();
        set_src(0, 8'h99, 1'b0, 1'b0);
        set_src(1, 8'h42, 1'b1, 1'b1);
        #1;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("to_quiet%0d", c), 32'(abort), 32'h0);
            tick();
        end
        chk("to_abort", 32'(abort), 32'h1);
        chk("to_abort_grant", 32'(grant), 32'h1);
        tick();
        set_src(0, 8'h98, 1'b1, 1'b1);
        #1;
        chk("to_abort_once", 32'(abort), 32'h0);
        chk("to_idle_grant", 32'(grant), 32'h0);
        tick();
        chk("to_next_grant", 32'(grant), 32'h2);
        chk("to_next_hdr", 32'(bus.tx_data), 32'hA1);

        // uart back-pressure: outputs hold, nothing accepted, no abort
        do_reset();
        set_src(2, 8'h3C, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hdr_data", 32'(bus.tx_data), 32'hA2);
            chk("bp_hdr_valid", 32'(bus.tx_valid), 32'h1);
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        #1;
        for (int c = 0; c < 50; c++) begin
            chk("bp_data", 32'(bus.tx_data), 32'h3C);
            chk("bp_valid", 32'(bus.tx_valid), 32'h1);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_abort", 32'(abort), 32'h0);
            tick();
        end
        bus.tx_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk("bp_done_grant", 32'(grant), 32'h0);

        // Reset mid-packet, then source 0 wins the tie
        do_reset();
        set_src(2, 8'h5A, 1'b1, 1'b0);
        bus.tx_ready = 1'b1;
        tick();
        tick();
        chk("rm_data_valid", 32'(bus.tx_valid), 32'h1);
        chk("rm_data_grant", 32'(grant), 32'h4);
        rst = 1'b0;
        set_src(0, 8'h01, 1'b1, 1'b1);
        #1;
        chk("rm_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rm_grant", 32'(grant), 32'h0);
        chk("rm_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rm_tx_data", 32'(bus.tx_data), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rm_tie_grant", 32'(grant), 32'h1);
        chk("rm_tie_hdr", 32'(bus.tx_data), 32'hA0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
